serv_state_wide: RTL

- Parametrised successor of the SERV instruction-sequencing/state block.
- Processes W bits per cycle (W = 1, 2, 4, 8), so one pass over a 32-bit operand takes 32/W cycles.
- Owns the bit counter, two-stage (INIT/RUN) sequencing, ibus/dbus/RF/MDU handshakes, branch decision and misalignment trap capture.
- Sits between the decoder and the serial/narrow datapath (ALU, bufreg, CSR, RF interface).

---
 rtl/serv_pkg.sv | 10 +
 rtl/serv_bitcnt.sv | 41 ++++
 rtl/serv_state_wide.sv | 126 ++++++++++++
 3 files changed

// File: rtl/serv_pkg.sv
// Shared constants and helpers for the narrow-datapath SERV state logic.
package serv_pkg;
  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  // Only power-of-two slice widths that divide XLEN evenly are supported.
  function automatic bit legal_w(input int w);
    return (w == 1) || (w == 2) || (w == 4) || (w == 8);
  endfunction
endpackage

// File: rtl/serv_bitcnt.sv
// W-step bit counter: one pass walks o_cnt from 0 to 32-W, then returns to idle.
module serv_bitcnt
  import serv_pkg::*;
#(
  parameter int W = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_cnt_en,
  output logic             o_cnt0,
  output logic             o_cnt_done
);
  localparam logic [CNT_W-1:0] STEP = CNT_W'(W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - W);

  logic [CNT_W-1:0] r_cnt;
  logic             r_cnt_en;
  logic             w_done;

  assign w_done = r_cnt_en & (r_cnt == LAST);

  // The final increment wraps to zero, leaving the idle state at o_cnt = 0.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_cnt_en <= 1'b0;
    end else if (r_cnt_en) begin
      r_cnt <= r_cnt + STEP;
      if (w_done) r_cnt_en <= 1'b0;
    end else if (i_start) begin
      r_cnt_en <= 1'b1;
    end
  end

  assign o_cnt      = r_cnt;
  assign o_cnt_en   = r_cnt_en;
  assign o_cnt0     = r_cnt_en & (r_cnt == '0);
  assign o_cnt_done = w_done;
endmodule

// File: rtl/serv_state_wide.sv
// Instruction sequencing for a W-bit-per-cycle SERV core: INIT/RUN stages,
// bus/RF/MDU handshakes, branch decision and misalignment trap capture.
module serv_state_wide
  import serv_pkg::*;
#(
  parameter int W              = 1,
  parameter int WITH_CSR       = 1,
  parameter int MDU            = 0,
  parameter     RESET_STRATEGY = "MINI"
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_new_irq,
  input  logic       i_ibus_ack,
  output logic       o_ibus_cyc,
  input  logic       i_dbus_ack,
  output logic       o_dbus_cyc,
  input  logic       i_mem_misalign,
  input  logic       i_ctrl_misalign,
  output logic       o_rf_rreq,
  output logic       o_rf_wreq,
  input  logic       i_rf_ready,
  output logic       o_rf_rd_en,
  input  logic       i_cond_branch,
  input  logic       i_bne_or_bge,
  input  logic       i_alu_cmp,
  input  logic       i_branch_op,
  input  logic       i_mem_op,
  input  logic       i_shift_op,
  input  logic       i_sh_right,
  input  logic       i_slt_op,
  input  logic       i_e_op,
  input  logic       i_rd_op,
  input  logic       i_mdu_op,
  input  logic       i_sh_done,
  output logic       o_mdu_valid,
  input  logic       i_mdu_ready,
  output logic [4:0] o_cnt,
  output logic       o_cnt_en,
  output logic       o_cnt0,
  output logic       o_cnt_done,
  output logic       o_init,
  output logic       o_ctrl_pc_en,
  output logic       o_ctrl_jump,
  output logic       o_ctrl_trap,
  output logic [1:0] o_mem_bytecnt,
  output logic       o_bufreg_en
);
  localparam logic HAS_CSR  = 1'(WITH_CSR != 0);
  localparam logic HAS_MDU  = 1'(MDU != 0);
  localparam logic RST_CTRL = 1'(RESET_STRATEGY != "NONE");

  if (!legal_w(W)) begin : g_illegal_w
    $error("serv_state_wide: W must be 1, 2, 4 or 8");
  end

  logic r_init_done;
  logic r_ctrl_jump;
  logic r_trap;
  logic r_stage_two_req;
  logic r_ibus_cyc;
  logic w_two_stage;
  logic w_take_branch;
  logic w_cnt_en;
  logic w_cnt_done;

  serv_bitcnt #(.W(W)) u_bitcnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_rf_ready),
    .o_cnt      (o_cnt),
    .o_cnt_en   (w_cnt_en),
    .o_cnt0     (o_cnt0),
    .o_cnt_done (w_cnt_done)
  );

  assign w_two_stage   = i_slt_op | i_mem_op | i_branch_op | i_shift_op | (HAS_MDU & i_mdu_op);
  assign w_take_branch = i_branch_op & (~i_cond_branch | (i_alu_cmp ^ i_bne_or_bge));

  assign o_cnt_en      = w_cnt_en;
  assign o_cnt_done    = w_cnt_done;
  assign o_mem_bytecnt = o_cnt[4:3];
  assign o_init        = w_two_stage & ~i_new_irq & ~r_init_done;
  assign o_ctrl_pc_en  = w_cnt_en & ~o_init;
  assign o_ctrl_jump   = r_ctrl_jump;
  assign o_ctrl_trap   = HAS_CSR & (i_e_op | i_new_irq | r_trap);
  assign o_ibus_cyc    = r_ibus_cyc & i_rst_n;
  assign o_dbus_cyc    = ~w_cnt_en & r_init_done & i_mem_op & ~i_mem_misalign;
  assign o_mdu_valid   = HAS_MDU & ~w_cnt_en & r_init_done & i_mdu_op;
  assign o_rf_rd_en    = i_rd_op & ~o_init;
  assign o_rf_rreq     = i_ibus_ack | (r_stage_two_req & r_trap);

  // A captured trap suppresses every writeback source.
  assign o_rf_wreq = ~r_trap &
                     ((i_shift_op & (i_sh_done | ~i_sh_right) & ~w_cnt_en & r_init_done) |
                      (i_mem_op & i_dbus_ack) |
                      (HAS_MDU & i_mdu_ready) |
                      (r_stage_two_req & (i_slt_op | i_branch_op)));

  assign o_bufreg_en = (w_cnt_en & (o_init | o_ctrl_trap | i_branch_op)) |
                       (i_shift_op & ~r_stage_two_req & (i_sh_right | i_sh_done));

  // Held in reset during i_rst_n so the first cycle after release fetches.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ibus_cyc      <= 1'b1;
      r_stage_two_req <= 1'b0;
    end else begin
      r_stage_two_req <= w_cnt_done & o_init;
      if (i_ibus_ack | w_cnt_done) r_ibus_cyc <= o_ctrl_pc_en;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n && RST_CTRL) begin
      r_init_done <= 1'b0;
      r_ctrl_jump <= 1'b0;
      r_trap      <= 1'b0;
    end else if (w_cnt_done) begin
      r_init_done <= o_init;
      r_ctrl_jump <= o_init & w_take_branch;
      r_trap      <= HAS_CSR & o_init &
                     ((w_take_branch & i_ctrl_misalign) | (i_mem_op & i_mem_misalign));
    end
  end
endmodule
